// File: rtl/pdm_xcorr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdm_xcorr_pkg
// Description : Shared widths, defaults and lag type for the PDM multi-lag
//               cross-correlator and the direction-of-arrival logic.
// Revision    : 1.0 - initial release
// ============================================================================
package pdm_xcorr_pkg;

    // Defaults shared with the direction-of-arrival block
    localparam int DEF_MAX_WINDOW = 256;
    localparam int DEF_MAX_LAG    = 4;

    // Width needed to hold a window length / score of 0..max_window
    function automatic int cnt_width(input int max_window);
        return $clog2(max_window + 1);
    endfunction

    // Width of a signed lag in -max_lag..+max_lag
    function automatic int lag_width(input int max_lag);
        return $clog2(max_lag + 1) + 1;
    endfunction

    localparam int DEF_LAG_W = lag_width(DEF_MAX_LAG);

    // Signed lag as seen by downstream consumers at the default geometry
    typedef logic signed [DEF_LAG_W-1:0] lag_t;

endpackage
`default_nettype wire

// File: rtl/pdm_xcorr_multilag_lag_counter.sv
`default_nettype none
// ============================================================================
// Module      : pdm_lag_counter
// Description : Running mismatch score for one lag. Adds the newest mismatch
//               bit and removes the bit leaving the window once the window
//               has been filled.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_lag_counter
    import pdm_xcorr_pkg::*;
#(
    parameter int SCORE_W = cnt_width(DEF_MAX_WINDOW) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clear,
    input  logic               fill_ok,
    input  logic               new_bit,
    input  logic               old_bit,
    output logic [SCORE_W-1:0] score
);

    // Sliding-window update; the score never drops below zero because a
    // leaving bit was always counted when it entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= '0;
        end else if (clear) begin
            score <= '0;
        end else if (en) begin
            score <= score + SCORE_W'(new_bit) - SCORE_W'(old_bit & fill_ok);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pdm_xcorr_multilag.sv
`default_nettype none
// ============================================================================
// Module      : pdm_xcorr_multilag
// Description : Running-window cross-correlator for two PDM streams scoring
//               every lag in -MAX_LAG..+MAX_LAG and reporting the lag with
//               the fewest mismatches plus direction flags.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_xcorr_multilag
    import pdm_xcorr_pkg::*;
#(
    parameter int MAX_WINDOW = DEF_MAX_WINDOW,
    parameter int MAX_LAG    = DEF_MAX_LAG,
    parameter int CNT_W      = cnt_width(MAX_WINDOW),
    parameter int LAG_W      = lag_width(MAX_LAG)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    data_1,
    input  logic                    data_2,
    input  logic [CNT_W-1:0]        length,
    input  logic                    clear,
    output logic                    corr_valid,
    output logic signed [LAG_W-1:0] best_lag,
    output logic [CNT_W-1:0]        best_score,
    output logic                    pos,
    output logic                    neg
);

    // The live input sample is index 0 of the history view, so only
    // DEPTH-1 samples need to be stored.
    localparam int DEPTH = MAX_WINDOW + MAX_LAG + 1;
    localparam int HIST  = DEPTH - 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NLAG  = 2 * MAX_LAG + 1;

    logic [HIST-1:0]  h1, h2;
    logic [DEPTH-1:0] hv1, hv2;
    logic [CNT_W-1:0] len_q, len_clamped;
    logic [IDX_W-1:0] fill, fill_full, len_idx;
    logic             fill_ok, add_ok;
    logic [CNT_W:0]   scores [NLAG];
    logic [CNT_W:0]   sel_score;
    logic signed [LAG_W-1:0] sel_lag;

    assign hv1       = {h1, data_1};
    assign hv2       = {h2, data_2};
    assign len_idx   = IDX_W'(len_q);
    assign fill_full = IDX_W'(len_q) + IDX_W'(MAX_LAG);
    assign fill_ok   = (fill >= fill_full);
    // The first MAX_LAG samples would pair with not-yet-seen history, so
    // they are kept out of the scores entirely.
    assign add_ok    = (fill >= IDX_W'(MAX_LAG));

    // Window length requested on clear, clamped to 1..MAX_WINDOW
    always_comb begin
        len_clamped = length;
        if (length == '0) begin
            len_clamped = CNT_W'(1);
        end else if (length > CNT_W'(MAX_WINDOW)) begin
            len_clamped = CNT_W'(MAX_WINDOW);
        end
    end

    // History shift registers, latched window length and warm-up counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1    <= '0;
            h2    <= '0;
            fill  <= '0;
            len_q <= CNT_W'(MAX_WINDOW);
        end else if (clear) begin
            h1    <= '0;
            h2    <= '0;
            fill  <= '0;
            len_q <= len_clamped;
        end else if (en) begin
            h1 <= hv1[HIST-1:0];
            h2 <= hv2[HIST-1:0];
            if (!fill_ok) begin
                fill <= fill + IDX_W'(1);
            end
        end
    end

    // One running score per lag; lag = j - MAX_LAG
    for (genvar j = 0; j < NLAG; j++) begin : g_lag
        localparam int K = j - MAX_LAG;
        localparam int A = (K < 0) ? -K : K;
        logic new_bit, old_bit;

        if (K > 0) begin : g_pos
            // data_2 lags data_1: pair x1 delayed by A with x2
            assign new_bit = hv1[A] ^ hv2[0];
            assign old_bit = hv1[len_idx + IDX_W'(A)] ^ hv2[len_idx];
        end else if (K < 0) begin : g_neg
            assign new_bit = hv1[0] ^ hv2[A];
            assign old_bit = hv1[len_idx] ^ hv2[len_idx + IDX_W'(A)];
        end else begin : g_zero
            assign new_bit = hv1[0] ^ hv2[0];
            assign old_bit = hv1[len_idx] ^ hv2[len_idx];
        end

        pdm_lag_counter #(
            .SCORE_W (CNT_W + 1)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .clear   (clear),
            .fill_ok (fill_ok),
            .new_bit (new_bit & add_ok),
            .old_bit (old_bit),
            .score   (scores[j])
        );
    end

    // Argmin in priority order 0, -1, +1, -2, +2 ... so strict '<' gives
    // smaller |k| first and the negative lag on an equal-magnitude tie.
    always_comb begin
        sel_score = scores[MAX_LAG];
        sel_lag   = '0;
        for (int m = 1; m <= MAX_LAG; m++) begin
            if (scores[MAX_LAG - m] < sel_score) begin
                sel_score = scores[MAX_LAG - m];
                sel_lag   = LAG_W'(-m);
            end
            if (scores[MAX_LAG + m] < sel_score) begin
                sel_score = scores[MAX_LAG + m];
                sel_lag   = LAG_W'(m);
            end
        end
    end

    // Registered result, forced to zero until the window is full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_valid <= 1'b0;
            best_lag   <= '0;
            best_score <= '0;
            pos        <= 1'b0;
            neg        <= 1'b0;
        end else if (clear || !fill_ok) begin
            corr_valid <= 1'b0;
            best_lag   <= '0;
            best_score <= '0;
            pos        <= 1'b0;
            neg        <= 1'b0;
        end else begin
            corr_valid <= 1'b1;
            best_lag   <= sel_lag;
            best_score <= sel_score[CNT_W] ? '1 : sel_score[CNT_W-1:0];
            pos        <= !sel_lag[LAG_W-1] && (sel_lag != '0);
            neg        <= sel_lag[LAG_W-1];
        end
    end

endmodule
`default_nettype wire
